// File: rtl/grn_pkg.sv
// Shared constants and helpers for gene-node (GRN) datapath blocks.
//   - Default gene-state and step-counter widths.
//   - clamp_div: forces a rate divider to be at least 1.
//   - phase_w:   phase-counter width for a divider, never less than 1 bit.
package grn_pkg;

  localparam int unsigned DefWidth = 1;
  localparam int unsigned DefCntW  = 16;

  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < 1) ? 1 : div;
  endfunction

  function automatic int unsigned phase_w(input int unsigned div);
    int unsigned c;
    c = clamp_div(div);
    return (c <= 2) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/grn_rate_div.sv
// Strobe rate divider: emits one fire pulse every DIV start strobes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (phase clears to 0)
//   start      : input strobe to be divided
//   load       : synchronous preload; phase goes to DIV-1 so the next start fires
//   freeze     : stall; start is ignored and phase holds
//   fire       : combinational, high in the cycle whose start completes the count
module grn_rate_div
  import grn_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic load,
  input  logic freeze,
  output logic fire
);

  localparam int unsigned DivC   = clamp_div(DIV);
  localparam int unsigned PhaseW = phase_w(DIV);
  localparam logic [PhaseW-1:0] Last = PhaseW'(DivC - 1);

  logic [PhaseW-1:0] phase_q, phase_d;

  assign fire = start & ~load & ~freeze & (phase_q == Last);

  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = Last;
    end else if (!freeze && start) begin
      phase_d = (phase_q == Last) ? '0 : phase_q + PhaseW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/no_vav_gen.sv
// Two-copy gene node for tortoise/hare attractor detection.
// s0 (slow copy) updates once per SLOW_DIV start_s0 strobes, s1 (fast copy) on every
// start_s1 strobe. A saturating step counter tracks fast updates, and match flags
// s0==s1 once at least one fast step has been taken.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   reset_nos         : synchronous re-init; loads init_state into both copies
//   init_state        : value loaded on reset_nos
//   start_s0/start_s1 : slow / fast update strobes
//   freeze            : stall; all state holds and strobes are dropped
//   next_s0/next_s1   : next-state values from the network update logic
//   s0, s1            : state registers
//   vav_s0, vav_s1    : copies of s0/s1 broadcast to neighbour nodes
//   step_cnt          : fast updates since last reset_nos (saturating)
//   cnt_sat           : sticky, step_cnt reached all-ones
//   match             : registered (s0==s1 && step_cnt!=0), one cycle behind state
module no_vav_gen
  import grn_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned SLOW_DIV = 2,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset_nos,
  input  logic [WIDTH-1:0] init_state,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic             freeze,
  input  logic [WIDTH-1:0] next_s0,
  input  logic [WIDTH-1:0] next_s1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] vav_s0,
  output logic [WIDTH-1:0] vav_s1,
  output logic [CNT_W-1:0] step_cnt,
  output logic             cnt_sat,
  output logic             match
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             match_q, match_d;
  logic             s0_fire;

  grn_rate_div #(
    .DIV (SLOW_DIV)
  ) u_rate_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s0),
    .load   (reset_nos),
    .freeze (freeze),
    .fire   (s0_fire)
  );

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    match_d = match_q;
    if (reset_nos) begin
      s0_d    = init_state;
      s1_d    = init_state;
      cnt_d   = '0;
      sat_d   = 1'b0;
      match_d = 1'b0;
    end else if (!freeze) begin
      // s0_fire already folds in freeze/reset_nos priority
      if (s0_fire) begin
        s0_d = next_s0;
      end
      if (start_s1) begin
        s1_d = next_s1;
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CntMax) begin
          sat_d = 1'b1;
        end
      end
      // Built from the current register outputs, so match trails the state by one edge
      match_d = (s0_q == s1_q) && (cnt_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= '0;
      s1_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      match_q <= match_d;
    end
  end

  assign s0       = s0_q;
  assign s1       = s1_q;
  assign vav_s0   = s0_q;
  assign vav_s1   = s1_q;
  assign step_cnt = cnt_q;
  assign cnt_sat  = sat_q;
  assign match    = match_q;

endmodule
